// File: rtl/wave_seq_pkg.sv
// ---------------------------------------------------------------------------
// wave_seq_pkg
//   Shared types and constants for the wave sequencer slice.
//   - FREQ_W : width of the waves_generator frequency code
//   - DUR_W  : default width of a segment duration
//   - seg_t  : one segment table entry {type_wave, freq, dur}
//   - state_e: sequencer FSM states
// ---------------------------------------------------------------------------
package wave_seq_pkg;

    localparam int FREQ_W = 4;
    localparam int DUR_W  = 16;

    typedef struct packed {
        logic              type_wave;
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
    } seg_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/wave_seq_table.sv
// ---------------------------------------------------------------------------
// wave_seq_table
//   N_SEG-entry segment register file. One synchronous write port, one
//   asynchronous read port. Contents are deliberately not reset so a
//   programmed table survives a sequencer reset.
// Ports
//   clock    in  system clock
//   wr_en    in  write strobe
//   wr_addr  in  write address (writes to addresses >= N_SEG are dropped)
//   wr_type  in  wave type field to store
//   wr_freq  in  frequency code field to store
//   wr_dur   in  duration field to store
//   rd_addr  in  read address
//   rd_type  out wave type of entry rd_addr
//   rd_freq  out frequency code of entry rd_addr
//   rd_dur   out duration of entry rd_addr
// ---------------------------------------------------------------------------
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter  int N_SEG = 8,
    parameter  int DUR_W = 16,
    localparam int IDX_W = $clog2(N_SEG)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic              wr_type,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic              rd_type,
    output logic [FREQ_W-1:0] rd_freq,
    output logic [DUR_W-1:0]  rd_dur
);

    logic              mem_type [N_SEG];
    logic [FREQ_W-1:0] mem_freq [N_SEG];
    logic [DUR_W-1:0]  mem_dur  [N_SEG];

    always_ff @(posedge clock) begin
        if (wr_en && (int'(wr_addr) < N_SEG)) begin
            mem_type[wr_addr] <= wr_type;
            mem_freq[wr_addr] <= wr_freq;
            mem_dur[wr_addr]  <= wr_dur;
        end
    end

    assign rd_type = mem_type[rd_addr];
    assign rd_freq = mem_freq[rd_addr];
    assign rd_dur  = mem_dur[rd_addr];

endmodule

// File: rtl/wave_sequencer.sv
// ---------------------------------------------------------------------------
// wave_sequencer
//   Drives type_wave/inp_freq of the wave generator from a programmable
//   segment table. Plays cfg_len segments in order, once or looped, under
//   start/stop control.
// Configuration macro
//   WAVE_SEQ_TICK_EN : adds input sample_tick; segment durations then count
//                      sample ticks instead of clock cycles.
// Ports
//   clock       in  system clock, all logic on posedge
//   reset       in  synchronous active-high reset (table kept)
//   sample_tick in  duration count enable (WAVE_SEQ_TICK_EN builds only)
//   cfg_we      in  table write strobe
//   cfg_addr    in  table write address
//   cfg_type    in  entry wave type (1=sin, 0=sawtooth)
//   cfg_freq    in  entry frequency code
//   cfg_dur     in  entry duration (0 behaves as 1)
//   cfg_len     in  segments to play, 1..N_SEG, sampled on start
//   loop_en     in  wrap to segment 0 after last, sampled on start
//   start       in  start request, honoured in IDLE only
//   stop        in  abort request, highest priority in PLAY
//   type_wave   out wave type to waves_generator
//   inp_freq    out frequency code to waves_generator
//   seg_idx     out index of segment currently driven
//   busy        out high while playing
//   done        out one-cycle pulse at end of a one-shot run
// ---------------------------------------------------------------------------
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter  int N_SEG = 8,
    parameter  int DUR_W = wave_seq_pkg::DUR_W,
    localparam int IDX_W = $clog2(N_SEG),
    localparam int LEN_W = $clog2(N_SEG) + 1
) (
    input  logic              clock,
    input  logic              reset,
`ifdef WAVE_SEQ_TICK_EN
    input  logic              sample_tick,
`endif
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic              cfg_type,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic [DUR_W-1:0]  cfg_dur,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic              type_wave,
    output logic [FREQ_W-1:0] inp_freq,
    output logic [IDX_W-1:0]  seg_idx,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                loop_q, loop_d;
    logic                type_d;
    logic [FREQ_W-1:0]   freq_d;
    logic [IDX_W-1:0]    idx_d;
    logic                busy_d;
    logic                done_d;

    logic                tick;
    logic                len_ok;
    logic                last_seg;
    logic                seg_end;
    logic                load;
    logic [IDX_W-1:0]    rd_addr;
    logic                rd_type;
    logic [FREQ_W-1:0]   rd_freq;
    logic [DUR_W-1:0]    rd_dur;

    // A zero duration plays as a single count so every segment is visible.
    function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

`ifdef WAVE_SEQ_TICK_EN
    assign tick = sample_tick;
`else
    assign tick = 1'b1;
`endif

    assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(N_SEG));
    assign last_seg = ({1'b0, seg_idx} == (len_q - LEN_W'(1)));
    assign seg_end  = tick && (dur_cnt_q == DUR_W'(1));

    wave_seq_table #(
        .N_SEG (N_SEG),
        .DUR_W (DUR_W)
    ) u_table (
        .clock   (clock),
        .wr_en   (cfg_we),
        .wr_addr (cfg_addr),
        .wr_type (cfg_type),
        .wr_freq (cfg_freq),
        .wr_dur  (cfg_dur),
        .rd_addr (rd_addr),
        .rd_type (rd_type),
        .rd_freq (rd_freq),
        .rd_dur  (rd_dur)
    );

    // Next-state and next-output logic. The table is read asynchronously at
    // the address of the segment about to be loaded, so a load happens on
    // the same edge as the previous segment's end (no gap cycle). A write to
    // that entry on the same edge is seen only on its next load.
    always_comb begin
        state_d   = state_q;
        dur_cnt_d = dur_cnt_q;
        len_d     = len_q;
        loop_d    = loop_q;
        type_d    = type_wave;
        freq_d    = inp_freq;
        idx_d     = seg_idx;
        done_d    = 1'b0;
        load      = 1'b0;
        rd_addr   = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop && len_ok) begin
                    state_d = PLAY;
                    len_d   = cfg_len;
                    loop_d  = loop_en;
                    load    = 1'b1;
                end
            end
            PLAY: begin
                // stop outranks both segment advance and run completion
                if (stop) begin
                    state_d = IDLE;
                end else if (seg_end) begin
                    if (!last_seg) begin
                        rd_addr = seg_idx + IDX_W'(1);
                        load    = 1'b1;
                    end else if (loop_q) begin
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (tick) begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            idx_d     = rd_addr;
            type_d    = rd_type;
            freq_d    = rd_freq;
            dur_cnt_d = clamp_dur(rd_dur);
        end

        busy_d = (state_d == PLAY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            dur_cnt_q <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            type_wave <= 1'b0;
            inp_freq  <= '0;
            seg_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_cnt_q <= dur_cnt_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            type_wave <= type_d;
            inp_freq  <= freq_d;
            seg_idx   <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wave_sequencer
//   Self-checking bench for wave_sequencer: directed vector table, hand
//   sequences for multi-cycle corners, and randomized stimulus compared
//   every cycle against a segment-level reference model.
// ---------------------------------------------------------------------------
module tb_wave_sequencer;
    import wave_seq_pkg::*;

    localparam int N_SEG = 8;
    localparam int DW    = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
`ifdef WAVE_SEQ_TICK_EN
    logic        sample_tick = 1'b1;
`endif
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic        cfg_type = 1'b0;
    logic [3:0]  cfg_freq = '0;
    logic [DW-1:0] cfg_dur = '0;
    logic [3:0]  cfg_len = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        type_wave;
    logic [3:0]  inp_freq;
    logic [2:0]  seg_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    wave_sequencer #(.N_SEG(N_SEG), .DUR_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef WAVE_SEQ_TICK_EN
        .sample_tick (sample_tick),
`endif
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_type    (cfg_type),
        .cfg_freq    (cfg_freq),
        .cfg_dur     (cfg_dur),
        .cfg_len     (cfg_len),
        .loop_en     (loop_en),
        .start       (start),
        .stop        (stop),
        .type_wave   (type_wave),
        .inp_freq    (inp_freq),
        .seg_idx     (seg_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Table image plus "which segment is on, how many counts remain".
    int mt [N_SEG];
    int mf [N_SEG];
    int md [N_SEG];
    bit m_run = 0;
    int m_idx = 0, m_rem = 0, m_len = 0;
    bit m_loop = 0;
    int m_type_o = 0, m_freq_o = 0;
    bit m_done = 0;

    task automatic model_load(input int i);
        m_idx    = i;
        m_type_o = mt[i];
        m_freq_o = mf[i];
        m_rem    = (md[i] == 0) ? 1 : md[i];
    endtask

    task automatic model_edge();
        int tk;
`ifdef WAVE_SEQ_TICK_EN
        tk = int'(sample_tick);
`else
        tk = 1;
`endif
        if (reset) begin
            m_run = 0; m_done = 0; m_idx = 0; m_type_o = 0; m_freq_o = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (start && !stop && cfg_len >= 1 && int'(cfg_len) <= N_SEG) begin
                    m_len  = int'(cfg_len);
                    m_loop = loop_en;
                    model_load(0);
                    m_run = 1;
                end
            end else if (stop) begin
                m_run = 0;
            end else if (tk != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_idx + 1 < m_len) model_load(m_idx + 1);
                    else if (m_loop)       model_load(0);
                    else begin m_run = 0; m_done = 1; end
                end
            end
        end
        // table write lands after any load on the same edge
        if (cfg_we) begin
            mt[cfg_addr] = int'(cfg_type);
            mf[cfg_addr] = int'(cfg_freq);
            md[cfg_addr] = int'(cfg_dur);
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        check("model.type_wave", int'(type_wave), m_type_o);
        check("model.inp_freq",  int'(inp_freq),  m_freq_o);
        check("model.seg_idx",   int'(seg_idx),   m_idx);
        check("model.busy",      int'(busy),      int'(m_run));
        check("model.done",      int'(done),      int'(m_done));
    endtask

    // One clock: inputs stay stable across the edge, outputs sampled at negedge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        model_edge();
        compare_model();
    endtask

    task automatic write_entry(input int a, input int t, input int f, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_type = 1'(t);
        cfg_freq = 4'(f);
        cfg_dur  = DW'(d);
        step();
        cfg_we   = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit start;
        int exp_type;
        int exp_freq;
        int exp_idx;
        int exp_busy;
        int exp_done;
    } vec_t;

    vec_t vt [7];

    task automatic run_vectors(input string tag);
        cfg_len = 4'd2;
        loop_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            start = vt[i].start;
            step();
            start = 1'b0;
            check({tag, ".type"}, int'(type_wave), vt[i].exp_type);
            check({tag, ".freq"}, int'(inp_freq),  vt[i].exp_freq);
            check({tag, ".idx"},  int'(seg_idx),   vt[i].exp_idx);
            check({tag, ".busy"}, int'(busy),      vt[i].exp_busy);
            check({tag, ".done"}, int'(done),      vt[i].exp_done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        seg_t e;

        vt[0] = '{1, 1, 3, 0, 1, 0};
        vt[1] = '{0, 1, 3, 0, 1, 0};
        vt[2] = '{0, 1, 3, 0, 1, 0};
        vt[3] = '{0, 0, 7, 1, 1, 0};
        vt[4] = '{0, 0, 7, 1, 1, 0};
        vt[5] = '{0, 0, 7, 1, 0, 1};
        vt[6] = '{0, 0, 7, 1, 0, 0};
        for (int i = 0; i < N_SEG; i++) begin mt[i] = 0; mf[i] = 0; md[i] = 0; end

        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        check("reset.busy", int'(busy), 0);
        check("reset.freq", int'(inp_freq), 0);
        reset = 1'b0;

        // one-shot from the vector table
        write_entry(0, 1, 3, 3);
        write_entry(1, 0, 7, 2);
        run_vectors("oneshot");

        // reset mid-run, then replay shows the table was kept
        cfg_len = 4'd2; loop_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midreset.busy", int'(busy), 0);
            check("midreset.type", int'(type_wave), 0);
            check("midreset.freq", int'(inp_freq), 0);
            check("midreset.idx",  int'(seg_idx), 0);
            check("midreset.done", int'(done), 0);
        end
        reset = 1'b0;
        run_vectors("replay");

        // bad lengths are ignored
        cfg_len = 4'd0; start = 1'b1;
        step();
        check("badlen0.busy", int'(busy), 0);
        cfg_len = 4'd9;
        step();
        check("badlen9.busy", int'(busy), 0);
        start = 1'b0;
        step();
        check("badlen.idle", int'(busy), 0);

        // loop with a zero-duration segment: 5,2,2,5,2,2,...
        write_entry(0, 1, 5, 0);
        write_entry(1, 0, 2, 2);
        cfg_len = 4'd2; loop_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            check("loop.freq", int'(inp_freq), (k % 3 == 0) ? 5 : 2);
            check("loop.done", int'(done), 0);
            check("loop.busy", int'(busy), 1);
        end
        // k=11 is the last count of seg1: stop+start on the advance edge
        stop = 1'b1; start = 1'b1;
        step();
        check("stopadv.busy", int'(busy), 0);
        check("stopadv.idx",  int'(seg_idx), 1);
        check("stopadv.freq", int'(inp_freq), 2);
        check("stopadv.done", int'(done), 0);
        stop = 1'b0; start = 1'b0;
        step();
        check("stopadv.hold", int'(busy), 0);
        // stop while the one-count seg0 is about to advance
        start = 1'b1;
        step();
        stop = 1'b1;
        step();
        check("stopseg0.busy", int'(busy), 0);
        check("stopseg0.idx",  int'(seg_idx), 0);
        check("stopseg0.freq", int'(inp_freq), 5);
        stop = 1'b0; start = 1'b0;
        step();
        check("stopseg0.done", int'(done), 0);

        // live rewrite of entry0 while it plays
        write_entry(0, 1, 3, 4);
        write_entry(1, 0, 7, 1);
        cfg_len = 4'd2; loop_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("rewrite.k0", int'(inp_freq), 3);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_type = 1'b1; cfg_freq = 4'd9; cfg_dur = DW'(4);
        step();
        cfg_we = 1'b0;
        check("rewrite.k1", int'(inp_freq), 3);
        for (int k = 2; k < 11; k++) begin
            step();
            check("rewrite.freq", int'(inp_freq), (k < 4) ? 3 : (k == 4 || k == 9) ? 7 : 9);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

`ifdef WAVE_SEQ_TICK_EN
        // tick every 4th cycle, dur=2 -> seg0 held 8 cycles
        write_entry(0, 1, 4, 2);
        write_entry(1, 0, 6, 1);
        cfg_len = 4'd2; loop_en = 1'b0;
        cnt = 0;
        for (int c = 3; c < 15; c++) begin
            sample_tick = ((c % 4) == 3);
            start = (c == 3);
            step();
            if (busy && seg_idx == 3'd0) cnt++;
        end
        start = 1'b0;
        sample_tick = 1'b1;
        check("tick.seg0_cycles", cnt, 8);
        stop = 1'b1;
        step();
        stop = 1'b0;
`endif

        // randomized run against the model
        for (int i = 0; i < N_SEG; i++) begin
            e.type_wave = 1'($urandom_range(0, 1));
            e.freq      = 4'($urandom_range(0, 15));
            e.dur       = DW'($urandom_range(0, 4));
            write_entry(i, int'(e.type_wave), int'(e.freq), int'(e.dur));
        end
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_type = 1'($urandom_range(0, 1));
            cfg_freq = 4'($urandom_range(0, 15));
            cfg_dur  = DW'($urandom_range(0, 5));
            cfg_len  = 4'($urandom_range(0, 9));
            loop_en  = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 29) == 0);
`ifdef WAVE_SEQ_TICK_EN
            sample_tick = 1'($urandom_range(0, 1));
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
